// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, return-address stack and a three-state memory fetch FSM.
// Latency: zero-wait memory gives ir_valid two cycles after fetch_req is sampled in IDLE.
// Backpressure: mem_rd/mem_addr hold until mem_ack or TIMEOUT; fetch/redirect ignored while busy.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 4,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic        call_push,
    input  logic        ret_pop,
    input  logic [15:0] pc_target,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic        busy,
    output logic [15:0] pc,
    output logic        stack_err,
    output logic        timeout_err
);

    // The wait counter only has to reach TIMEOUT-1: that is the last REQ cycle.
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [SPW-1:0] SP_FULL   = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_pc;
    logic [31:0]     r_ir;
    logic [CW-1:0]   r_wait;
    logic [SPW-1:0]  r_sp;
    logic [15:0]     r_stack [STACK_DEPTH];
    logic            r_stack_err;
    logic            r_timeout_err;

    logic            w_idle;
    logic            w_do_ret;
    logic            w_do_call;
    logic            w_do_load;
    logic            w_full;
    logic            w_empty;
    logic            w_ack;
    logic            w_timeout;
    logic [IW-1:0]   w_top_idx;
    logic [IW-1:0]   w_push_idx;

    // Redirects are only honoured in IDLE; return beats call beats jump.
    assign w_idle     = (r_state == S_IDLE);
    assign w_do_ret   = w_idle && ret_pop;
    assign w_do_call  = w_idle && call_push && !ret_pop;
    assign w_do_load  = w_idle && pc_load && !ret_pop && !call_push;
    assign w_full     = (r_sp == SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_top_idx  = IW'(r_sp - SPW'(1));
    assign w_push_idx = IW'(r_sp);

    // A late ack on the final allowed cycle wins over the timeout.
    assign w_ack      = (r_state == S_REQ) && mem_ack;
    assign w_timeout  = (r_state == S_REQ) && !mem_ack && (r_wait == WAIT_LAST);

    // FSM state register; async reset aborts any in-flight read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-state strobes, decoded from the registered state only.
    always_comb begin
        w_next   = r_state;
        mem_rd   = 1'b0;
        busy     = 1'b0;
        ir_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_req) w_next = S_REQ;
            end
            S_REQ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (mem_ack)                  w_next = S_DONE;
                else if (r_wait == WAIT_LAST) w_next = S_IDLE;
            end
            S_DONE: begin
                busy     = 1'b1;
                ir_valid = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Wait counter runs only in REQ, so it is zero on every REQ entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                r_wait <= '0;
        else if (r_state == S_REQ) r_wait <= r_wait + CW'(1);
        else                       r_wait <= '0;
    end

    // Program counter: increment on a completed fetch, otherwise apply an IDLE redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_ack) begin
            r_pc <= r_pc + 16'd1;
        end else if (w_do_ret) begin
            if (!w_empty) r_pc <= r_stack[w_top_idx];
        end else if (w_do_call || w_do_load) begin
            r_pc <= pc_target;
        end
    end

    // Instruction register captures the word accepted in REQ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     r_ir <= '0;
        else if (w_ack) r_ir <= mem_rdata;
    end

    // Stack pointer; overflowing calls and underflowing returns leave it untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                      r_sp <= '0;
        else if (w_do_ret && !w_empty)   r_sp <= r_sp - SPW'(1);
        else if (w_do_call && !w_full)   r_sp <= r_sp + SPW'(1);
    end

    // Stack storage; emptiness is tracked by the pointer so entries need no reset.
    always_ff @(posedge clock) begin
        if (w_do_call && !w_full) r_stack[w_push_idx] <= r_pc;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stack_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((w_do_ret && w_empty) || (w_do_call && w_full)) r_stack_err <= 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign IR          = r_ir;
    assign stack_err   = r_stack_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetches, redirects, stack and timeout cases.
// Expected IR/pc per fetch are queued by the stimulus and popped on each ir_valid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

    localparam int TO = 255;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic        call_push;
    logic        ret_pop;
    logic [15:0] pc_target;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] IR;
    logic        ir_valid;
    logic        busy;
    logic [15:0] pc;
    logic        stack_err;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    instr_fetch_unit #(
        .RESET_PC    (16'h0000),
        .STACK_DEPTH (4),
        .TIMEOUT     (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .call_push   (call_push),
        .ret_pop     (ret_pop),
        .pc_target   (pc_target),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .pc          (pc),
        .stack_err   (stack_err),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ir_valid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && ir_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir_valid: got IR=%h pc=%h, expected no pulse", IR, pc);
            end else begin
                e = sb.pop_front();
                chk("ir_on_valid", IR, e.ir);
                chk("pc_on_valid", 32'(pc), 32'(e.pc));
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},          32'(pc),          32'h0000);
        chk({tag, "_ir"},          IR,               32'h0);
        chk({tag, "_ir_valid"},    32'(ir_valid),    32'h0);
        chk({tag, "_mem_rd"},      32'(mem_rd),      32'h0);
        chk({tag, "_busy"},        32'(busy),        32'h0);
        chk({tag, "_stack_err"},   32'(stack_err),   32'h0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        #1;
        chk_reset("rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One fetch: optional same-cycle jump to addr, ack after dly REQ cycles,
    // optional noise (fetch/redirect/ack) driven while busy that must be ignored.
    task automatic fetch(input logic [15:0] addr, input logic [31:0] data,
                         input int dly, input bit ld, input bit noise);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        sb.push_back('{ir: data, pc: nxt});
        fetch_req = 1'b1;
        if (ld) begin
            pc_load   = 1'b1;
            pc_target = addr;
        end
        @(negedge clock);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            chk("mem_rd_req", 32'(mem_rd), 32'h1);
            chk("mem_addr",   32'(mem_addr), 32'(addr));
            chk("busy_req",   32'(busy), 32'h1);
            if (noise) begin
                fetch_req = 1'b1;
                pc_load   = 1'b1;
                call_push = 1'b1;
                ret_pop   = 1'b1;
                pc_target = 16'hBAD0;
            end
            if (i == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
            end
            @(negedge clock);
        end
        mem_ack = noise;
        if (noise) mem_rdata = 32'hFFFF_FFFF;
        chk("busy_done",   32'(busy), 32'h1);
        chk("mem_rd_done", 32'(mem_rd), 32'h0);
        @(negedge clock);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        call_push = 1'b0;
        ret_pop   = 1'b0;
        mem_ack   = 1'b0;
        chk("busy_idle",     32'(busy), 32'h0);
        chk("ir_valid_idle", 32'(ir_valid), 32'h0);
        chk("pc_idle",       32'(pc), 32'(nxt));
        chk("ir_hold",       IR, data);
    endtask

    task automatic redir(input bit ld, input bit call, input bit ret,
                         input logic [15:0] tgt, input logic [15:0] exp_pc,
                         input bit exp_err, input string name);
        pc_load   = ld;
        call_push = call;
        ret_pop   = ret;
        pc_target = tgt;
        @(negedge clock);
        pc_load   = 1'b0;
        call_push = 1'b0;
        ret_pop   = 1'b0;
        chk(name,              32'(pc), 32'(exp_pc));
        chk({name, "_err"},    32'(stack_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b0;
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        call_push = 1'b0;
        ret_pop   = 1'b0;
        pc_target = 16'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk_reset("por");
        @(negedge clock);
        reset = 1'b1;

        // Zero-wait fetch from RESET_PC, then a three-cycle-delayed ack.
        fetch(16'h0000, 32'h0100_0000, 0, 1'b0, 1'b0);
        fetch(16'h0001, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);

        // PC wrap.
        redir(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, "load_ffff");
        fetch(16'hFFFF, 32'hA5A5_0001, 1, 1'b0, 1'b0);

        // Call/return and underflow.
        redir(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0, "load_5");
        redir(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0040, 1'b0, "call_40");
        redir(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0005, 1'b0, "ret_5");
        redir(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0005, 1'b1, "ret_empty");
        chk("timeout_err_clear", 32'(timeout_err), 32'h0);

        // Overflow with depth 4, then LIFO unwind.
        rst_pulse();
        redir(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, "load_100");
        redir(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0200, 1'b0, "call1");
        redir(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0300, 1'b0, "call2");
        redir(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0400, 1'b0, "call3");
        redir(1'b0, 1'b1, 1'b0, 16'h0500, 16'h0500, 1'b0, "call4");
        redir(1'b0, 1'b1, 1'b0, 16'h0600, 16'h0600, 1'b1, "call5_full");
        redir(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0400, 1'b1, "pop1");
        redir(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300, 1'b1, "pop2");
        redir(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 1'b1, "pop3");
        redir(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0100, 1'b1, "pop4");

        // Priority: call over jump, then return over both.
        redir(1'b1, 1'b1, 1'b0, 16'h0777, 16'h0777, 1'b1, "prio_call");
        redir(1'b1, 1'b1, 1'b1, 16'h0999, 16'h0100, 1'b1, "prio_ret");

        // Jump in the same cycle as fetch_req; then a fetch with ignored noise.
        fetch(16'h0020, 32'h1234_5678, 0, 1'b1, 1'b0);
        fetch(16'h0021, 32'h0BAD_F00D, 2, 1'b0, 1'b1);

        // Ack on the last allowed cycle succeeds.
        fetch(16'h0022, 32'hCAFE_0022, TO - 1, 1'b0, 1'b0);
        chk("ack_last_no_timeout", 32'(timeout_err), 32'h0);

        // No ack at all: abandoned after TO cycles.
        fetch_req = 1'b1;
        @(negedge clock);
        fetch_req = 1'b0;
        n = 0;
        while (mem_rd && n < TO + 10) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_rd_cycles", n, TO);
        chk("timeout_err_set",   32'(timeout_err), 32'h1);
        chk("timeout_idle",      32'(busy), 32'h0);
        chk("timeout_pc",        32'(pc), 32'h0023);
        chk("timeout_ir",        IR, 32'hCAFE_0022);

        // Reset in the middle of REQ; a late ack must be ignored.
        fetch_req = 1'b1;
        @(negedge clock);
        fetch_req = 1'b0;
        chk("second_req_rd", 32'(mem_rd), 32'h1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk_reset("async");
        mem_ack   = 1'b1;
        mem_rdata = 32'hFEED_FACE;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("late_ack_busy", 32'(busy), 32'h0);
        chk("late_ack_ir",   IR, 32'h0);
        chk("late_ack_pc",   32'(pc), 32'h0000);
        chk("late_ack_rd",   32'(mem_rd), 32'h0);

        // First fetch after reset reads RESET_PC.
        fetch(16'h0000, 32'h00C0_FFEE, 0, 1'b0, 1'b0);

        @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address stack entries.
REQ-003 Parameter TIMEOUT, default 255, maximum REQ-state cycles waiting for mem_ack.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 fetch_req  input  1  control unit fetch request (ir_load); sampled in IDLE only.
REQ-007 pc_load  input  1  jump: PC <= pc_target.
REQ-008 call_push  input  1  call: push PC, then PC <= pc_target.
REQ-009 ret_pop  input  1  return: PC <= popped address.
REQ-010 pc_target  input  16  jump/call destination.
REQ-011 mem_rd  output  1  instruction memory read strobe.
REQ-012 mem_addr  output  16  word address of read.
REQ-013 mem_ack  input  1  memory data valid.
REQ-014 mem_rdata  input  32  instruction word.
REQ-015 IR  output  32  latched instruction register.
REQ-016 ir_valid  output  1  one-cycle pulse when IR is updated.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 pc  output  16  current program counter.
REQ-019 stack_err  output  1  sticky: push when full or pop when empty.
REQ-020 timeout_err  output  1  sticky: fetch abandoned after TIMEOUT cycles.

Function
REQ-021 FSM states IDLE, REQ, DONE; IDLE->REQ on fetch_req; REQ->DONE on mem_ack; REQ->IDLE on timeout; DONE->IDLE unconditionally.
REQ-022 In REQ: mem_rd=1, mem_addr=pc, both held stable until mem_ack or timeout; mem_rd=0 in all other states.
REQ-023 mem_ack high in REQ: IR <= mem_rdata, pc <= pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-024 ir_valid=1 only in DONE, exactly one cycle; zero-wait memory gives ir_valid two cycles after fetch_req sampled.
REQ-025 mem_ack outside REQ is ignored; fetch_req outside IDLE is ignored (no queuing).
REQ-026 Redirect inputs (pc_load, call_push, ret_pop) are sampled in IDLE only; ignored while busy.
REQ-027 Redirect priority when several are high: ret_pop > call_push > pc_load.
REQ-028 call_push, stack not full: push pc, pc <= pc_target; stack full: no push, pc <= pc_target, stack_err <= 1.
REQ-029 ret_pop, stack not empty: pc <= top entry, pop; stack empty: pc unchanged, stack_err <= 1.
REQ-030 Stack is LIFO of STACK_DEPTH 16-bit entries; no overwrite on overflow.
REQ-031 Redirect and fetch_req in same IDLE cycle: pc updated at that edge, REQ then fetches from the new pc.
REQ-032 Wait counter clears on REQ entry; if TIMEOUT cycles elapse without mem_ack: timeout_err <= 1, IR and pc unchanged, no ir_valid, return to IDLE.
REQ-033 mem_ack on the final allowed cycle counts as success, not timeout.
REQ-034 stack_err and timeout_err clear only on reset.

Reset
REQ-035 reset low forces immediately: state IDLE, pc=RESET_PC, IR=0, ir_valid=0, mem_rd=0, busy=0, stack empty, stack_err=0, timeout_err=0, wait counter 0.
REQ-036 reset mid-fetch aborts the read; mem_rd drops without waiting for clock; a late mem_ack after reset release is ignored.
REQ-037 First fetch after reset reads address RESET_PC.

Verification
REQ-038 Reset, fetch_req 1 cycle, mem_ack same cycle as mem_rd, mem_rdata=32'h01000000 -> mem_addr=0, IR=32'h01000000, ir_valid one pulse 2 cycles after request, pc=1.
REQ-039 Memory delays ack 3 cycles -> mem_rd and mem_addr stable 4 cycles, single ir_valid, busy high for REQ+DONE cycles only.
REQ-040 pc=16'hFFFF, fetch completes -> pc=16'h0000.
REQ-041 pc=5, call_push target 16'h0040 -> pc=16'h0040; ret_pop -> pc=5; ret_pop again -> pc=5, stack_err=1.
REQ-042 Five call_push with STACK_DEPTH=4 -> fifth sets stack_err, pc=fifth target; four pops return last four pushed values in reverse order.
REQ-043 No mem_ack for TIMEOUT cycles -> timeout_err=1, state IDLE, IR and pc unchanged; reset during second fetch's REQ -> mem_rd=0 asynchronously, all outputs at reset values.
